// File: rtl/level_sequencer.sv
// Player session sequencer: login, level selection, level-1 round counting,
// timed-level control, interrupt/pause handling and a high-score scan.
module level_sequencer #(
  parameter int NUM_PLAYERS = 8,
  parameter int NUM_LEVELS  = 4,
  parameter int ROUNDS_L1   = 10,
  parameter int T_BASE      = 90,
  parameter int T_STEP      = 15,
  parameter int ID_W        = $clog2(NUM_PLAYERS),
  parameter int LV_W        = $clog2(NUM_LEVELS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 auth_ok,
  input  logic [ID_W-1:0]                      user_id,
  input  logic                                 go,
  input  logic [LV_W-1:0]                      level_sel,
  input  logic                                 round_done,
  input  logic [7:0]                           score_in,
  input  logic                                 timer_timeout,
  input  logic                                 wdog_timeout,
  output logic [LV_W-1:0]                      level,
  output logic [7:0]                           timer_preset,
  output logic                                 timer_load,
  output logic                                 timer_en,
  output logic                                 wdog_en,
  output logic                                 score_clr,
  output logic [$clog2(ROUNDS_L1+1)-1:0]       round_cnt,
  output logic                                 logout,
  output logic [ID_W-1:0]                      winner_id,
  output logic [8+$clog2(NUM_LEVELS)-1:0]      winner_total,
  output logic                                 winner_valid
);

  localparam int RC_W  = $clog2(ROUNDS_L1 + 1);
  localparam int TOT_W = 8 + $clog2(NUM_LEVELS);
  localparam logic [LV_W-1:0] LAST_LV  = LV_W'(NUM_LEVELS);
  localparam logic [LV_W-1:0] HS_LEVEL = LV_W'(NUM_LEVELS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_L1_PLAY, S_T_CFG, S_T_ARM, S_T_WAIT, S_T_PLAY,
    S_T_DONE, S_INTERRUPT, S_PAUSE, S_RESUME, S_LOGOUT, S_HS_SCAN, S_HS_SHOW
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]       pid_q;
  logic [LV_W-1:0]       level_q;
  logic [7:0]            preset_q;
  logic [RC_W-1:0]       round_q;
  logic [ID_W-1:0]       scan_idx_q;
  logic [TOT_W-1:0]      max_q;
  logic [ID_W-1:0]       max_id_q;
  logic [NUM_LEVELS-1:0] unlock_q [NUM_PLAYERS];
  // best_q[p][k] holds the best score of timed level k+2
  logic [7:0]            best_q   [NUM_PLAYERS][NUM_LEVELS-1];

  logic [LV_W-1:0]  target;
  logic [TOT_W-1:0] scan_total;
  logic             go_eff;
  state_t           resume_state;

  function automatic logic [7:0] preset_for(input logic [LV_W-1:0] lv);
    int v;
    v = T_BASE - (int'(lv) - 2) * T_STEP;
    if (v < 1) v = 1;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  // Watchdog expiry takes precedence over a simultaneous go everywhere.
  assign go_eff       = go & ~wdog_timeout;
  assign resume_state = (level_q == LV_W'(1)) ? S_L1_PLAY : S_T_PLAY;

  always_comb begin
    target = LV_W'(1);
    for (int l = 2; l <= NUM_LEVELS; l++) begin
      if (unlock_q[pid_q][l-1] && (int'(level_sel) >= l)) target = LV_W'(l);
    end
  end

  always_comb begin
    scan_total = '0;
    for (int k = 0; k < NUM_LEVELS - 1; k++) begin
      scan_total = scan_total + TOT_W'(best_q[scan_idx_q][k]);
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    wdog_en    = 1'b0;
    score_clr  = 1'b0;
    logout     = 1'b0;
    case (state_q)
      S_IDLE:    if (auth_ok) state_d = S_SELECT;
      S_SELECT: begin
        if (go_eff) begin
          if (level_sel == '0)        state_d = S_HS_SCAN;
          else if (target == LV_W'(1)) state_d = S_L1_PLAY;
          else                         state_d = S_T_CFG;
        end
      end
      S_L1_PLAY: begin
        wdog_en = 1'b1;
        if (go_eff) state_d = S_INTERRUPT;
      end
      S_T_CFG:   state_d = S_T_ARM;
      S_T_ARM: begin
        timer_load = 1'b1;
        score_clr  = 1'b1;
        state_d    = S_T_WAIT;
      end
      S_T_WAIT:  if (go_eff) state_d = S_T_PLAY;
      S_T_PLAY: begin
        timer_en = 1'b1;
        wdog_en  = 1'b1;
        if (timer_timeout) state_d = S_T_DONE;
        else if (go_eff)   state_d = S_INTERRUPT;
      end
      S_T_DONE: begin
        if (go_eff) state_d = (level_q < LAST_LV) ? S_T_CFG : S_SELECT;
      end
      S_INTERRUPT: begin
        wdog_en = 1'b1;
        if (wdog_timeout) state_d = resume_state;
        else if (go)      state_d = S_PAUSE;
      end
      S_PAUSE: begin
        wdog_en = 1'b1;
        if (wdog_timeout) state_d = S_RESUME;
        else if (go)      state_d = S_LOGOUT;
      end
      S_RESUME:  if (go_eff) state_d = resume_state;
      S_LOGOUT: begin
        logout    = 1'b1;
        score_clr = 1'b1;
        state_d   = S_IDLE;
      end
      S_HS_SCAN: if (scan_idx_q == ID_W'(NUM_PLAYERS - 1)) state_d = S_HS_SHOW;
      S_HS_SHOW: if (go_eff) state_d = S_SELECT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pid_q      <= '0;
      level_q    <= '0;
      preset_q   <= 8'(T_BASE);
      round_q    <= '0;
      scan_idx_q <= '0;
      max_q      <= '0;
      max_id_q   <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        unlock_q[p] <= NUM_LEVELS'(1);
        for (int k = 0; k < NUM_LEVELS - 1; k++) best_q[p][k] <= 8'd0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (auth_ok) pid_q <= user_id;
        S_SELECT: begin
          if (state_d == S_HS_SCAN) begin
            level_q    <= HS_LEVEL;
            scan_idx_q <= '0;
            max_q      <= '0;
            max_id_q   <= '0;
          end else if (state_d != S_SELECT) begin
            level_q <= target;
            if (state_d == S_T_CFG) preset_q <= preset_for(target);
          end
        end
        S_L1_PLAY: begin
          if (round_done) begin
            if (round_q == RC_W'(ROUNDS_L1 - 1)) begin
              round_q         <= '0;
              unlock_q[pid_q] <= unlock_q[pid_q] | NUM_LEVELS'(2);
            end else begin
              round_q <= round_q + RC_W'(1);
            end
          end
        end
        S_T_PLAY: begin
          if (state_d == S_T_DONE) begin
            for (int l = 2; l <= NUM_LEVELS; l++) begin
              if ((level_q == LV_W'(l)) && (score_in > best_q[pid_q][l-2]))
                best_q[pid_q][l-2] <= score_in;
            end
            if (level_q < LAST_LV)
              unlock_q[pid_q] <= unlock_q[pid_q] | (NUM_LEVELS'(1) << level_q);
          end
        end
        S_T_DONE: begin
          if (state_d == S_T_CFG) begin
            level_q  <= level_q + LV_W'(1);
            preset_q <= preset_for(level_q + LV_W'(1));
          end
        end
        S_LOGOUT: level_q <= '0;
        S_HS_SCAN: begin
          scan_idx_q <= scan_idx_q + ID_W'(1);
          // strict compare keeps the lowest index on ties
          if (scan_total > max_q) begin
            max_q    <= scan_total;
            max_id_q <= scan_idx_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign level        = level_q;
  assign timer_preset = preset_q;
  assign round_cnt    = round_q;
  assign winner_id    = max_id_q;
  assign winner_total = max_q;
  assign winner_valid = (state_q == S_HS_SHOW) && (max_q != '0);

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_PLAYERS, 8: number of player records.
- NUM_LEVELS, 4: level 1 untimed, levels 2..NUM_LEVELS timed.
- ROUNDS_L1, 10: level-1 rounds needed to unlock level 2.
- T_BASE, 90: level-2 timer preset in seconds.
- T_STEP, 15: preset reduction per higher level.
- ID_W = clog2(NUM_PLAYERS) and LV_W = clog2(NUM_LEVELS+1), both derived.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-low.
- auth_ok, in, 1: login granted.
- user_id, in, ID_W: current player.
- go, in, 1: single-cycle control pulse.
- level_sel, in, LV_W: requested level; 0 requests the high-score view.
- round_done, in, 1: single-cycle pulse, round completed.
- score_in, in, 8: live score, binary.
- timer_timeout, in, 1: countdown expired.
- wdog_timeout, in, 1: inactivity watchdog expired.
- level, out, LV_W: active level; NUM_LEVELS+1 in the high-score view.
- timer_preset, out, 8: preset value for the countdown timer.
- timer_load, out, 1: one-cycle load strobe.
- timer_en, out, 1: countdown run enable.
- wdog_en, out, 1: watchdog enable.
- score_clr, out, 1: one-cycle clear strobe for the live score.
- round_cnt, out, clog2(ROUNDS_L1+1): level-1 round count.
- logout, out, 1: one-cycle logout pulse.
- winner_id, out, ID_W: high-score winner.
- winner_total, out, 8+clog2(NUM_LEVELS): winner's total score.
- winner_valid, out, 1: winner fields are valid.

Function
REQ-003 Per player, the block SHALL store an unlock vector of NUM_LEVELS bits (bit 0 always 1) and one 8-bit best score for each timed level.
REQ-004 The state machine SHALL have the states IDLE, SELECT, L1_PLAY, T_CFG, T_ARM, T_WAIT, T_PLAY, T_DONE, INTERRUPT, PAUSE, RESUME, LOGOUT, HS_SCAN and HS_SHOW.
REQ-005 IDLE SHALL advance to SELECT when auth_ok=1; user_id SHALL be sampled into an internal pid at that transition.
REQ-006 In SELECT with go=1:
- level_sel=0 SHALL go to HS_SCAN.
- Otherwise the target level SHALL be the highest unlocked level ≤ min(level_sel, NUM_LEVELS).
- Target 1 SHALL go to L1_PLAY; any other target SHALL go to T_CFG.
REQ-007 L1_PLAY behaviour:
- wdog_en=1 throughout.
- Each round_done SHALL increment round_cnt.
- When the count reaches ROUNDS_L1, the block SHALL set unlock bit 1 and clear round_cnt to 0 in the same cycle.
REQ-008 T_CFG SHALL set timer_preset = T_BASE − (level−2)·T_STEP, saturating at 1, and SHALL go to T_ARM.
REQ-009 T_ARM SHALL pulse timer_load and score_clr together for exactly 1 cycle, then go to T_WAIT.
REQ-010 T_WAIT SHALL hold timer_en=0 and SHALL go to T_PLAY on go.
REQ-011 T_PLAY SHALL drive timer_en=1 and wdog_en=1; timer_timeout SHALL go to T_DONE with timer_en=0 on the next cycle.
REQ-012 On entry to T_DONE, the block SHALL perform exactly one record update:
- best[pid][level] = max(best, score_in).
- If level < NUM_LEVELS, unlock bit `level` SHALL be set.
REQ-013 T_DONE with go SHALL go to T_CFG of level+1 if level < NUM_LEVELS, otherwise to SELECT.
REQ-014 go in L1_PLAY or T_PLAY SHALL go to INTERRUPT with timer_en=0 and wdog_en=1.
REQ-015 INTERRUPT transitions:
- wdog_timeout SHALL resume the interrupted level: L1_PLAY, or T_PLAY with the timer not reloaded.
- go SHALL go to PAUSE.
REQ-016 PAUSE transitions:
- go SHALL go to LOGOUT.
- wdog_timeout SHALL go to RESUME.
REQ-017 RESUME SHALL return on go to the interrupted level with the timer not reloaded.
REQ-018 LOGOUT SHALL pulse logout and score_clr for 1 cycle, then go to IDLE; stored records SHALL be kept.
REQ-019 If timer_timeout and go are asserted in the same cycle in T_PLAY, timer_timeout SHALL win.
REQ-020 If wdog_timeout and go are asserted in the same cycle, wdog_timeout SHALL win.
REQ-021 HS_SCAN SHALL visit one player per cycle, index 0 to NUM_PLAYERS−1, computing the sum of best scores:
- The running maximum SHALL be replaced only on a strictly greater total, so the lowest index wins ties.
- After NUM_PLAYERS cycles the block SHALL enter HS_SHOW.
REQ-022 In HS_SHOW:
- winner_valid=1 if and only if the maximum total is > 0; otherwise winner_id=0, winner_total=0 and winner_valid=0.
- go SHALL go to SELECT and clear winner_valid.
REQ-023 Total sums SHALL be computed at full width without overflow.

Reset
REQ-024 On rst=0 at a clock edge:
- state SHALL be IDLE.
- All outputs SHALL be 0, except level=0 and timer_preset=T_BASE.
- All records SHALL be cleared to "level 1 unlocked only, all scores 0".
REQ-025 Reset asserted in any state, including mid-scan, SHALL take effect on that edge and SHALL discard any partial record update.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Fresh player, level_sel=3 -> enters L1_PLAY; 10 round_done pulses -> unlock bit 1 set, round_cnt=0.
- Level 2 with score_in=42 at timeout -> best[pid][2]=42; go -> T_CFG with timer_preset=75.
- Replay level 2 with score_in=30 -> best stays 42.
- Player 2 total 70, player 5 total 70, others 0 -> HS_SHOW after 8 scan cycles with winner_id=2, winner_total=70, winner_valid=1.
- go in T_PLAY, go again, go again -> INTERRUPT, PAUSE, then LOGOUT with a logout pulse; player scores unchanged after re-login.
- timer_timeout and go in the same cycle -> T_DONE; rst=0 during HS_SCAN -> IDLE with all records cleared.
